// File: rtl/jtframe_mbox.sv
// Two-way mailbox between a main CPU and an MCU: one strobe-driven circular FIFO per direction.
// Optional sticky overflow flags are built only when JTFRAME_MBOX_OVF_EN is defined.

module jtframe_mbox_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          we,
    input  logic          rd,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   cnt,
    output logic          full,
    output logic          ovf
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          we_prev_q, we_prev_d, we_arm_q, we_arm_d;
    logic          rd_prev_q, rd_prev_d, rd_arm_q, rd_arm_d;
    logic          push, pop, empty, do_push, do_pop, mem_we;

    // A strobe only acts once it has been seen low since reset, so a strobe held
    // across reset cannot trigger a transfer until it is released and re-asserted.
    always_comb begin
        we_prev_d = we;
        rd_prev_d = rd;
        we_arm_d  = we_arm_q | ~we;
        rd_arm_d  = rd_arm_q | ~rd;
        push      = we & ~we_prev_q & we_arm_q;
        pop       = ~rd & rd_prev_q & rd_arm_q;
    end

    assign empty   = (cnt_q == '0);
    assign full    = cnt_q[AW];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        mem_we   = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                hold_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            we_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
            we_arm_q  <= ~we;
            rd_arm_q  <= ~rd;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            we_prev_q <= we_prev_d;
            rd_prev_q <= rd_prev_d;
            we_arm_q  <= we_arm_d;
            rd_arm_q  <= rd_arm_d;
        end
    end

    // Storage is not reset; the hold register covers the empty case.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= din;
    end

    assign dout = empty ? hold_q : mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

`ifdef JTFRAME_MBOX_OVF_EN
    logic ovf_q, ovf_d;

    // A push into a full FIFO is only dropped when no pop frees a slot that cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (clr) ovf_d = 1'b0;
        else if (push & full & ~do_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

module jtframe_mbox #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          main_we,
    input  logic          main_rd,
    input  logic [DW-1:0] main_din,
    output logic [DW-1:0] main_dout,
    input  logic          main_clr,
    input  logic          mcu_we,
    input  logic          mcu_rd,
    input  logic [DW-1:0] mcu_din,
    output logic [DW-1:0] mcu_dout,
    output logic          mcu_irq,
    output logic          main_stn,
    output logic          m2s_full,
    output logic          s2m_full,
    output logic [AW:0]   m2s_cnt,
    output logic [AW:0]   s2m_cnt,
    output logic [1:0]    ovf
);
    logic m2s_ovf, s2m_ovf;

    jtframe_mbox_fifo #(.DW(DW), .AW(AW)) u_m2s (
        .clk  (clk),
        .rst  (rst),
        .clr  (main_clr),
        .we   (main_we),
        .rd   (mcu_rd),
        .din  (main_din),
        .dout (mcu_dout),
        .cnt  (m2s_cnt),
        .full (m2s_full),
        .ovf  (m2s_ovf)
    );

    jtframe_mbox_fifo #(.DW(DW), .AW(AW)) u_s2m (
        .clk  (clk),
        .rst  (rst),
        .clr  (main_clr),
        .we   (mcu_we),
        .rd   (main_rd),
        .din  (mcu_din),
        .dout (main_dout),
        .cnt  (s2m_cnt),
        .full (s2m_full),
        .ovf  (s2m_ovf)
    );

    // Status lines come straight from the registered counts.
    assign mcu_irq  = (m2s_cnt != '0);
    assign main_stn = (s2m_cnt == '0);
    assign ovf      = {s2m_ovf, m2s_ovf};

endmodule

// File: tb/tb_jtframe_mbox.sv
// Bench for jtframe_mbox: directed scenarios with literal expectations, then
// random traffic compared every cycle against a queue-based mailbox model.

module tb_jtframe_mbox;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          main_we = 1'b0, main_rd = 1'b0, main_clr = 1'b0;
    logic          mcu_we = 1'b0, mcu_rd = 1'b0;
    logic [DW-1:0] main_din = '0, mcu_din = '0;
    logic [DW-1:0] main_dout, mcu_dout;
    logic          mcu_irq, main_stn, m2s_full, s2m_full;
    logic [AW:0]   m2s_cnt, s2m_cnt;
    logic [1:0]    ovf;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    jtframe_mbox #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .main_we   (main_we),
        .main_rd   (main_rd),
        .main_din  (main_din),
        .main_dout (main_dout),
        .main_clr  (main_clr),
        .mcu_we    (mcu_we),
        .mcu_rd    (mcu_rd),
        .mcu_din   (mcu_din),
        .mcu_dout  (mcu_dout),
        .mcu_irq   (mcu_irq),
        .main_stn  (main_stn),
        .m2s_full  (m2s_full),
        .s2m_full  (s2m_full),
        .m2s_cnt   (m2s_cnt),
        .s2m_cnt   (s2m_cnt),
        .ovf       (ovf)
    );

    // Clock / reset
    always #5 clk = ~clk;

`ifdef JTFRAME_MBOX_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model: index 0 = main-to-MCU, index 1 = MCU-to-main.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] hold_m[2];
    bit            ovf_m[2];
    bit            wprev[2], warm[2], rprev[2], rarm[2];

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic model_dir(input int d, input bit w, input bit r, input logic [DW-1:0] din, input bit clr);
        bit push, pop, pop_ok, push_ok;
        int n;
        // A strobe held through reset must be released before it can act.
        push = w && !wprev[d] && warm[d];
        pop  = !r && rprev[d] && rarm[d];
        wprev[d] = w;
        rprev[d] = r;
        if (!w) warm[d] = 1'b1;
        if (!r) rarm[d] = 1'b1;
        if (clr) begin
            if (d == 0) q0.delete(); else q1.delete();
            ovf_m[d] = 1'b0;
        end else begin
            n       = qsize(d);
            pop_ok  = pop && (n > 0);
            push_ok = push && ((n < DEPTH) || pop_ok);
            if (push && !push_ok) ovf_m[d] = 1'b1;
            if (pop_ok) begin
                if (d == 0) hold_m[0] = q0.pop_front();
                else        hold_m[1] = q1.pop_front();
            end
            if (push_ok) begin
                if (d == 0) q0.push_back(din);
                else        q1.push_back(din);
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            for (int d = 0; d < 2; d++) begin
                hold_m[d] = '0;
                ovf_m[d]  = 1'b0;
                wprev[d]  = 1'b0;
                rprev[d]  = 1'b0;
            end
            warm[0] = !main_we;
            rarm[0] = !mcu_rd;
            warm[1] = !mcu_we;
            rarm[1] = !main_rd;
        end else begin
            model_dir(0, main_we, mcu_rd, main_din, main_clr);
            model_dir(1, mcu_we, main_rd, mcu_din, main_clr);
        end
    end

    // Compare process: every output, every cycle once the model is seeded.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mcu_dout",  mcu_dout,  (q0.size() != 0) ? q0[0] : hold_m[0]);
            chk("main_dout", main_dout, (q1.size() != 0) ? q1[0] : hold_m[1]);
            chk("m2s_cnt",   m2s_cnt,   q0.size());
            chk("s2m_cnt",   s2m_cnt,   q1.size());
            chk("m2s_full",  m2s_full,  q0.size() == DEPTH);
            chk("s2m_full",  s2m_full,  q1.size() == DEPTH);
            chk("mcu_irq",   mcu_irq,   q0.size() != 0);
            chk("main_stn",  main_stn,  q1.size() == 0);
            chk("ovf",       ovf,       OVF_ON ? {30'd0, ovf_m[1], ovf_m[0]} : 32'd0);
        end
    end

    // Driver tasks
    task automatic main_push(input logic [DW-1:0] d);
        main_din = d; main_we = 1'b1; tick();
        main_we = 1'b0; tick();
    endtask

    task automatic mcu_push(input logic [DW-1:0] d);
        mcu_din = d; mcu_we = 1'b1; tick();
        mcu_we = 1'b0; tick();
    endtask

    task automatic mcu_pop();
        mcu_rd = 1'b1; tick();
        mcu_rd = 1'b0; tick();
    endtask

    task automatic clear();
        main_clr = 1'b1; tick();
        main_clr = 1'b0; tick();
    endtask

    initial begin
        rst = 1'b1;
        tick(3);
        cmp_en = 1'b1;
        rst = 1'b0;
        tick();
        chk("rst_irq",  mcu_irq,   0);
        chk("rst_stn",  main_stn,  1);
        chk("rst_full", {m2s_full, s2m_full}, 0);
        chk("rst_dout", {mcu_dout, main_dout}, 0);

        // One push for a strobe held three cycles
        main_din = 8'h5A; main_we = 1'b1; tick();
        chk("push_cnt",  m2s_cnt,  1);
        chk("push_irq",  mcu_irq,  1);
        chk("push_head", mcu_dout, 8'h5A);
        tick(2);
        main_we = 1'b0; tick();
        chk("held_cnt",  m2s_cnt,  1);

        // Pop on falling edge of the read strobe
        mcu_rd = 1'b1; tick(4);
        chk("rd_held_cnt", m2s_cnt, 1);
        mcu_rd = 1'b0; tick();
        chk("pop_irq",  mcu_irq,  0);
        chk("pop_hold", mcu_dout, 8'h5A);

        // Overflow at depth 4
        for (int i = 1; i <= 5; i++) main_push(DW'(i));
        chk("ovf_full", m2s_full, 1);
        chk("ovf_cnt",  m2s_cnt,  4);
        chk("ovf_bit0", ovf[0],   OVF_ON);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_pop_head", mcu_dout, i);
            mcu_pop();
        end
        chk("drain_cnt",  m2s_cnt,  0);
        chk("drain_hold", mcu_dout, 4);
        clear();
        chk("clr_ovf", ovf, 0);

        // Push and pop together on a full FIFO
        for (int i = 0; i < 4; i++) mcu_push(8'h10 + DW'(i));
        chk("s2m_full", s2m_full, 1);
        chk("s2m_stn",  main_stn, 0);
        main_rd = 1'b1; tick();
        main_rd = 1'b0; mcu_din = 8'h14; mcu_we = 1'b1; tick();
        chk("both_cnt",  s2m_cnt,   4);
        chk("both_ovf",  ovf[1],    0);
        chk("both_head", main_dout, 8'h11);
        mcu_we = 1'b0; tick();

        // Clear wins over a concurrent push; held strobe does not retrigger
        clear();
        main_push(8'h21); main_push(8'h22);
        mcu_push(8'h31);  mcu_push(8'h32);
        chk("pre_clr_cnt", {m2s_cnt, s2m_cnt}, {3'd2, 3'd2});
        main_clr = 1'b1; mcu_din = 8'h33; mcu_we = 1'b1; tick();
        chk("clr_cnts", {m2s_cnt, s2m_cnt}, 0);
        chk("clr_irq",  mcu_irq,  0);
        chk("clr_stn",  main_stn, 1);
        chk("clr_ovf2", ovf,      0);
        main_clr = 1'b0; tick(2);
        chk("clr_noretrig", s2m_cnt, 0);
        mcu_we = 1'b0; tick();

        // Reset during a held write strobe
        main_din = 8'h44; main_we = 1'b1; tick();
        rst = 1'b1; tick(2);
        rst = 1'b0; tick(2);
        chk("rst_held_cnt", m2s_cnt, 0);
        main_we = 1'b0; tick();
        main_we = 1'b1; tick();
        chk("rst_rearm_cnt",  m2s_cnt,  1);
        chk("rst_rearm_head", mcu_dout, 8'h44);
        main_we = 1'b0; tick();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) main_we = ~main_we;
            if ($urandom_range(0, 2) == 0) main_rd = ~main_rd;
            if ($urandom_range(0, 2) == 0) mcu_we  = ~mcu_we;
            if ($urandom_range(0, 2) == 0) mcu_rd  = ~mcu_rd;
            main_din = DW'($urandom);
            mcu_din  = DW'($urandom);
            main_clr = ($urandom_range(0, 79) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; main_clr = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtframe_mbox.md
JTFRAME_MBOX -- requirements
Module: jtframe_mbox

Interface
REQ-001 The block SHALL take parameter DW, default 8, as the data width of both mailbox directions.
REQ-002 The block SHALL take parameter AW, default 2, as log2 of the FIFO depth; each direction holds 2**AW entries.
REQ-003 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock (24 MHz typ.).
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 main_we  in  1  main-CPU write strobe (level, may span many clk cycles).
REQ-007 main_rd  in  1  main-CPU read strobe (level).
REQ-008 main_din  in  DW  main-to-MCU data.
REQ-009 main_dout  out  DW  head of MCU-to-main FIFO.
REQ-010 main_clr  in  1  flush both FIFOs.
REQ-011 mcu_we  in  1  MCU write strobe (level).
REQ-012 mcu_rd  in  1  MCU read strobe (level).
REQ-013 mcu_din  in  DW  MCU-to-main data.
REQ-014 mcu_dout  out  DW  head of main-to-MCU FIFO.
REQ-015 mcu_irq  out  1  high while the main-to-MCU FIFO is non-empty.
REQ-016 main_stn  out  1  low while the MCU-to-main FIFO is non-empty.
REQ-017 m2s_full, s2m_full  out  1 each  FIFO full flags.
REQ-018 m2s_cnt, s2m_cnt  out  AW+1 each  FIFO occupancy.
REQ-019 ovf  out  2  sticky overflow flags {s2m, m2s} (see Configuration).

Function
REQ-020 Each direction SHALL be an independent circular FIFO with AW-bit read/write pointers wrapping modulo 2**AW and an AW+1-bit occupancy count.
REQ-021 A push SHALL occur only on the clk cycle where the write strobe is high and was low the previous cycle; holding the strobe high SHALL NOT push again.
REQ-022 A pop SHALL occur on the clk cycle where the read strobe is low and was high the previous cycle (falling edge), so the reader samples the head before it advances.
REQ-023 *_dout SHALL present the FIFO head entry, combinational from memory and the registered read pointer; when empty it SHALL hold the last popped value (0 after reset).
REQ-024 A push into a full FIFO SHALL be dropped, with pointers and count unchanged.
REQ-025 A pop from an empty FIFO SHALL be ignored.
REQ-026 Simultaneous push and pop on a non-empty FIFO SHALL both occur, leaving the count unchanged.
REQ-027 Simultaneous push and pop on a full FIFO SHALL both occur; the push SHALL NOT count as overflow.
REQ-028 Simultaneous push and pop on an empty FIFO SHALL perform only the push.
REQ-029 A pushed entry SHALL be visible at the reader (count, flags, head) on the cycle after the push edge.
REQ-030 mcu_irq, main_stn and full flags SHALL be derived from registered counts, with no combinational path from strobes.
REQ-031 main_clr high SHALL, on that cycle, zero both FIFOs' pointers and counts and clear ovf; it SHALL take priority over any push or pop that cycle.
REQ-032 main_clr SHALL NOT clear the edge-detect registers, so a strobe still held after the clear SHALL NOT re-trigger.

Reset
REQ-033 On rst, pointers, counts, edge-detect registers, ovf and dout hold registers SHALL clear: mcu_irq=0, main_stn=1, full flags=0, *_dout=0.
REQ-034 A reset asserted mid-strobe SHALL discard the transfer; a strobe still high when rst drops SHALL NOT push or pop until it falls and rises again.
REQ-035 FIFO memory contents need not be reset.

Configuration
REQ-036 Macro JTFRAME_MBOX_OVF_EN SHALL, when defined, make ovf[0] and ovf[1] set on a dropped push (REQ-024) in m2s and s2m respectively, staying set until main_clr or rst.
REQ-037 Without JTFRAME_MBOX_OVF_EN, ovf SHALL be tied to 2'b00 and no overflow logic SHALL be synthesised.

Verification
REQ-038 After reset, main_we pulse 3 cycles with main_din=8'h5A -> exactly one push; m2s_cnt=1, mcu_irq=1, mcu_dout=8'h5A on the next cycle.
REQ-039 mcu_rd high 4 cycles then low -> pop on the falling-edge cycle; mcu_irq=0 next cycle; mcu_dout holds 8'h5A.
REQ-040 AW=2: five main_we edges with data 1..5 -> m2s_full=1, m2s_cnt=4, data 5 dropped; ovf[0]=1 with JTFRAME_MBOX_OVF_EN, 0 without; pops return 1,2,3,4.
REQ-041 Full s2m FIFO, mcu_we rising edge on the same cycle as a main_rd falling edge -> s2m_cnt stays 4, ovf[1]=0, head advances by one.
REQ-042 Both FIFOs holding 2 entries, main_clr and mcu_we edge on the same cycle -> both counts 0, mcu_irq=0, main_stn=1, ovf=0.
REQ-043 rst asserted while main_we high, main_we kept high after release -> no push until main_we falls and rises again.
